// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: latches the decode bundle into EX, detects load-use hazards,
// injects bubbles on stall or flush and keeps a saturating count of injected bubbles.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_aluc,
  input  logic              id_alusrca,
  input  logic              id_alusrcb,
  input  logic              id_wrback,
  input  logic              id_regdst,
  input  logic              id_memwr,
  input  logic              id_regwr,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_sa,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [3:0]        ex_aluc,
  output logic              ex_alusrca,
  output logic              ex_alusrcb,
  output logic              ex_wrback,
  output logic              ex_regdst,
  output logic              ex_memwr,
  output logic              ex_regwr,
  output logic              ex_use_rs,
  output logic              ex_use_rt,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [4:0]        ex_sa,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_dest,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Control encodings shared with the decode stage.
  localparam logic FROM_DM = 1'b1;
  localparam logic FROM_RT = 1'b0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic              valid;
    logic [3:0]        aluc;
    logic              alusrca;
    logic              alusrcb;
    logic              wrback;
    logic              regdst;
    logic              memwr;
    logic              regwr;
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        sa;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [REG_AW-1:0] dest;
  } stage_t;

  stage_t id_s, ex_q;
  logic   bubble_inc;

  assign id_s = '{
    valid:   id_valid,
    aluc:    id_aluc,
    alusrca: id_alusrca,
    alusrcb: id_alusrcb,
    wrback:  id_wrback,
    regdst:  id_regdst,
    memwr:   id_memwr,
    regwr:   id_regwr,
    use_rs:  id_use_rs,
    use_rt:  id_use_rt,
    rs:      id_rs,
    rt:      id_rt,
    rd:      id_rd,
    sa:      id_sa,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    imm:     id_imm,
    pc4:     id_pc4,
    dest:    (id_regdst == FROM_RT) ? id_rt : id_rd
  };

  // A load in EX whose result ID needs now; $0 never creates a dependence.
  assign stall_o = ex_q.valid & ex_q.regwr & (ex_q.wrback == FROM_DM) & (ex_q.dest != '0)
                 & ((id_use_rs & (id_rs == ex_q.dest)) | (id_use_rt & (id_rt == ex_q.dest)))
                 & id_valid & ~flush;

  assign bubble_inc = flush ? id_valid : (~hold & stall_o);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush || (!hold && stall_o)) begin
        ex_q <= '0;
      end else if (!hold) begin
        ex_q <= id_s;
      end
      if (bubble_inc && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_aluc    = ex_q.aluc;
  assign ex_alusrca = ex_q.alusrca;
  assign ex_alusrcb = ex_q.alusrcb;
  assign ex_wrback  = ex_q.wrback;
  assign ex_regdst  = ex_q.regdst;
  assign ex_memwr   = ex_q.memwr;
  assign ex_regwr   = ex_q.regwr;
  assign ex_use_rs  = ex_q.use_rs;
  assign ex_use_rt  = ex_q.use_rt;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_rd      = ex_q.rd;
  assign ex_sa      = ex_q.sa;
  assign ex_rs_data = ex_q.rs_data;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm     = ex_q.imm;
  assign ex_pc4     = ex_q.pc4;
  assign ex_dest    = ex_q.dest;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed hazard scenarios then random traffic against a
// cycle-level reference model of the ID/EX stage.
module tb_id_ex_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam logic DM = 1'b1, ALU = 1'b0, RT = 1'b0, RD = 1'b1;

  typedef struct packed {
    logic valid; logic [3:0] aluc; logic alusrca; logic alusrcb; logic wrback;
    logic regdst; logic memwr; logic regwr; logic use_rs; logic use_rt;
    logic [AW-1:0] rs; logic [AW-1:0] rt; logic [AW-1:0] rd; logic [4:0] sa;
    logic [DW-1:0] rs_data; logic [DW-1:0] rt_data; logic [DW-1:0] imm; logic [DW-1:0] pc4;
  } ins_t;

  logic clk = 0, rst_n = 0, hold = 0, flush = 0;
  ins_t cur = '0;

  logic stall_o;
  ins_t obs;
  logic [AW-1:0] ex_dest;
  logic [CW-1:0] bubble_cnt;

  // reference state: contents of EX, its destination and the bubble count
  ins_t m_ex = '0;
  logic [AW-1:0] m_dest = '0;
  int m_cnt = 0;
  bit m_known = 0;

  int tests = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur.valid), .id_aluc(cur.aluc), .id_alusrca(cur.alusrca), .id_alusrcb(cur.alusrcb),
    .id_wrback(cur.wrback), .id_regdst(cur.regdst), .id_memwr(cur.memwr), .id_regwr(cur.regwr),
    .id_use_rs(cur.use_rs), .id_use_rt(cur.use_rt), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .id_sa(cur.sa), .id_rs_data(cur.rs_data), .id_rt_data(cur.rt_data), .id_imm(cur.imm),
    .id_pc4(cur.pc4), .hold(hold), .flush(flush), .stall_o(stall_o),
    .ex_valid(obs.valid), .ex_aluc(obs.aluc), .ex_alusrca(obs.alusrca), .ex_alusrcb(obs.alusrcb),
    .ex_wrback(obs.wrback), .ex_regdst(obs.regdst), .ex_memwr(obs.memwr), .ex_regwr(obs.regwr),
    .ex_use_rs(obs.use_rs), .ex_use_rt(obs.use_rt), .ex_rs(obs.rs), .ex_rt(obs.rt), .ex_rd(obs.rd),
    .ex_sa(obs.sa), .ex_rs_data(obs.rs_data), .ex_rt_data(obs.rt_data), .ex_imm(obs.imm),
    .ex_pc4(obs.pc4), .ex_dest(ex_dest), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    tests++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic ins_t mk(input logic regwr, wrback, regdst, memwr, use_rs, use_rt,
                              input int rs, rt, rd);
    ins_t i;
    i = '0;
    i.valid = 1; i.regwr = regwr; i.wrback = wrback; i.regdst = regdst; i.memwr = memwr;
    i.use_rs = use_rs; i.use_rt = use_rt;
    i.rs = AW'(rs); i.rt = AW'(rt); i.rd = AW'(rd);
    i.aluc = 4'($urandom); i.alusrca = 1'($urandom); i.alusrcb = 1'($urandom);
    i.sa = 5'($urandom);
    i.rs_data = $urandom; i.rt_data = $urandom; i.imm = $urandom; i.pc4 = $urandom;
    return i;
  endfunction

  function automatic ins_t lw(input int rt, rs);
    return mk(1, DM, RT, 0, 1, 0, rs, rt, $urandom_range(0, 31));
  endfunction
  function automatic ins_t add(input int rd, rs, rt);
    return mk(1, ALU, RD, 0, 1, 1, rs, rt, rd);
  endfunction

  // Apply one cycle of ID inputs; check the hazard output before the edge and EX after it.
  task automatic step(input ins_t i, input logic h, input logic f, input logic r);
    logic exp_stall;
    cur = i; hold = h; flush = f; rst_n = r;
    #2;
    exp_stall = m_ex.valid && m_ex.regwr && m_ex.wrback == DM && m_dest != 0 && i.valid && !f
                && ((i.use_rs && i.rs == m_dest) || (i.use_rt && i.rt == m_dest));
    if (m_known && r) chk("stall_o", 256'(stall_o), 256'(exp_stall));
    @(posedge clk);
    if (!r) begin
      m_ex = '0; m_dest = '0; m_cnt = 0; m_known = 1;
    end else if (f) begin
      m_ex = '0; m_dest = '0;
      if (i.valid) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
    end else if (h) begin
      // frozen
    end else if (exp_stall) begin
      m_ex = '0; m_dest = '0;
      m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
    end else begin
      m_ex = i;
      m_dest = (i.regdst == RT) ? i.rt : i.rd;
    end
    #1;
    chk("ex_fields", 256'(obs), 256'(m_ex));
    chk("ex_dest", 256'(ex_dest), 256'(m_dest));
    chk("bubble_cnt", 256'(bubble_cnt), 256'(m_cnt));
  endtask

  ins_t nop, addi, t;

  initial begin
    nop = '0;
    step(nop, 0, 0, 0);
    step(nop, 1, 1, 0);

    // ADDI r3: writes rt, no hazard
    addi = mk(1, ALU, RT, 0, 1, 0, 1, 3, 9);
    step(addi, 0, 0, 1);
    chk("addi_dest", 256'(ex_dest), 256'(3));
    chk("addi_regwr", 256'(obs.regwr), 256'(1));

    // LW r5 then ADD using r5: one bubble, then ADD advances
    step(lw(5, 2), 0, 0, 1);
    t = add(6, 5, 1);
    step(t, 0, 0, 1);
    chk("lu_bubble_valid", 256'(obs.valid), 256'(0));
    chk("lu_cnt", 256'(bubble_cnt), 256'(1));
    step(t, 0, 0, 1);
    chk("lu_add_dest", 256'(ex_dest), 256'(6));

    // LW r0 never stalls; SW with use_rt=0 on the load target does not stall
    step(lw(0, 2), 0, 0, 1);
    step(add(7, 0, 0), 0, 0, 1);
    step(lw(5, 2), 0, 0, 1);
    step(mk(0, ALU, RT, 1, 1, 0, 1, 5, 0), 0, 0, 1);

    // flush on top of a load-use hazard
    step(lw(7, 1), 0, 0, 1);
    step(add(8, 7, 2), 0, 1, 1);
    chk("flush_cnt", 256'(bubble_cnt), 256'(2));

    // hold for three cycles during a hazard, then a single bubble
    step(lw(4, 1), 0, 0, 1);
    t = add(9, 2, 4);
    repeat (3) step(t, 1, 0, 1);
    step(t, 0, 0, 1);
    step(t, 0, 0, 1);
    chk("hold_release_cnt", 256'(bubble_cnt), 256'(3));

    // reset mid-stream clears everything
    step(addi, 0, 0, 1);
    step(addi, 0, 0, 0);
    chk("rst_regwr", 256'(obs.regwr), 256'(0));

    // 20 stalls: counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      step(lw(1, 3), 0, 0, 1);
      step(add(2, 1, 3), 0, 0, 1);
    end
    chk("sat_cnt", 256'(bubble_cnt), 256'(15));

    // random traffic
    step(nop, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      t = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      t.valid = ($urandom_range(0, 9) != 0);
      step(t, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
